// File: rtl/ips_drive_sequencer.sv
// Mission controller: line following with soft-start ramp, timed box-avoidance
// manoeuvre (halt, reverse, pivot), box counting and end-of-track stop.
module ips_drive_sequencer #(
  parameter logic [15:0] MAX_WIDTH   = 16'd40000,
  parameter logic [15:0] RAMP_STEP   = 16'd400,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned DEB_CYC     = 1000,
  parameter int unsigned DWELL_CYC   = 100000000,
  parameter int unsigned REVERSE_CYC = 50000000,
  parameter int unsigned PIVOT_CYC   = 75000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  sensor,
  input  logic        us_stop,
  output logic [3:0]  direction,
  output logic [15:0] widthChassis,
  output logic [2:0]  state_out,
  output logic [3:0]  box_count,
  output logic        done
);

  localparam int unsigned TW = 32;

  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0101;
  localparam logic [3:0] DIR_FWD   = 4'b0110;
  localparam logic [3:0] DIR_RIGHT = 4'b1010;
  localparam logic [3:0] DIR_BACK  = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_HALT    = 3'd2,
    S_REVERSE = 3'd3,
    S_PIVOT   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [TW-1:0]   div_cnt, div_n;
  logic [TW-1:0]   us_cnt, us_cnt_n;
  logic [TW-1:0]   end_cnt, end_cnt_n;
  logic [15:0]     ramp, ramp_n;
  logic [3:0]      last_dir, last_dir_n;
  logic [3:0]      dir_n;
  logic [15:0]     width_n;
  logic [3:0]      box_n;
  logic            done_n;
  logic [2:0]      ind;
  logic [3:0]      steer;
  logic [16:0]     ramp_sum;
  logic            us_fire, end_fire;

  assign state_out = state;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      div_cnt      <= '0;
      us_cnt       <= '0;
      end_cnt      <= '0;
      ramp         <= '0;
      last_dir     <= DIR_FWD;
      direction    <= DIR_STOP;
      widthChassis <= '0;
      box_count    <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      div_cnt      <= div_n;
      us_cnt       <= us_cnt_n;
      end_cnt      <= end_cnt_n;
      ramp         <= ramp_n;
      last_dir     <= last_dir_n;
      direction    <= dir_n;
      widthChassis <= width_n;
      box_count    <= box_n;
      done         <= done_n;
    end
  end

  // Next state, counters and next output values
  always_comb begin
    state_n    = state;
    timer_n    = timer + TW'(1);
    div_n      = div_cnt;
    ramp_n     = ramp;
    last_dir_n = last_dir;
    box_n      = box_count;
    dir_n      = DIR_STOP;
    width_n    = '0;
    done_n     = 1'b0;
    ind        = ~sensor;
    ramp_sum   = 17'(ramp) + 17'(RAMP_STEP);

    // Debouncers saturate at the threshold so a held condition stays asserted
    if (!us_stop)                      us_cnt_n = '0;
    else if (us_cnt == TW'(DEB_CYC))   us_cnt_n = us_cnt;
    else                               us_cnt_n = us_cnt + TW'(1);
    if (ind != 3'b111)                 end_cnt_n = '0;
    else if (end_cnt == TW'(DEB_CYC))  end_cnt_n = end_cnt;
    else                               end_cnt_n = end_cnt + TW'(1);
    us_fire  = (us_cnt_n == TW'(DEB_CYC));
    end_fire = (end_cnt_n == TW'(DEB_CYC));

    case (ind)
      3'b001, 3'b011: steer = DIR_LEFT;
      3'b010:         steer = DIR_FWD;
      3'b100, 3'b110: steer = DIR_RIGHT;
      3'b101:         steer = DIR_BACK;
      default:        steer = last_dir;
    endcase

    case (state)
      S_IDLE: begin
        us_cnt_n  = '0;
        end_cnt_n = '0;
        if (enable) begin
          state_n = S_FOLLOW;
          ramp_n  = '0;
          div_n   = '0;
        end
      end
      S_FOLLOW: begin
        if (us_fire) begin
          state_n = S_HALT;
        end else if (end_fire) begin
          state_n = S_DONE;
        end else if (div_cnt == TW'(RAMP_DIV - 1)) begin
          div_n  = '0;
          ramp_n = (ramp_sum > 17'(MAX_WIDTH)) ? MAX_WIDTH : ramp_sum[15:0];
        end else begin
          div_n = div_cnt + TW'(1);
        end
      end
      S_HALT: begin
        if (timer == TW'(DWELL_CYC - 1)) begin
          state_n = S_REVERSE;
          box_n   = (box_count == 4'd15) ? box_count : box_count + 4'd1;
        end
      end
      S_REVERSE: begin
        if (timer == TW'(REVERSE_CYC - 1)) state_n = S_PIVOT;
      end
      S_PIVOT: begin
        if (timer == TW'(PIVOT_CYC - 1)) begin
          state_n  = S_FOLLOW;
          ramp_n   = '0;
          div_n    = '0;
          us_cnt_n = '0;
        end
      end
      S_DONE: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // Dropping enable overrides everything, including a pending box increment
    if (!enable) begin
      state_n = S_IDLE;
      box_n   = box_count;
      ramp_n  = '0;
      div_n   = '0;
    end

    if (state_n != state) timer_n = '0;

    case (state_n)
      S_FOLLOW: begin
        dir_n      = steer;
        width_n    = ramp_n;
        last_dir_n = steer;
      end
      S_REVERSE: begin
        dir_n   = DIR_BACK;
        width_n = MAX_WIDTH;
      end
      S_PIVOT: begin
        dir_n   = DIR_LEFT;
        width_n = MAX_WIDTH;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

endmodule
